fpu_word_driver: RTL

- Host-side initiator for the team's 16-bit word-serial FPU operand/result protocol.
- Accepts one 32-bit operand pair (a, b) per command and sends each operand to an FPU core (e.g. the divider) as a high word then a low word.
- Collects the two 16-bit result words, reassembles the 32-bit result and presents it to the host.
- Sits between a host command port and any two-operand FPU core using stb/ack word handshakes.

---
 rtl/fpu_word_driver_pkg.sv | 18 +
 rtl/fpu_hs_word.sv | 27 ++
 rtl/fpu_word_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_word_driver_pkg.sv
// rtl/fpu_word_driver_pkg.sv - shared widths and FSM state encoding for the word-serial FPU driver
package fpu_word_driver_pkg;

  localparam int WORD_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUT_A_HI = 3'd1,
    S_PUT_A_LO = 3'd2,
    S_PUT_B_HI = 3'd3,
    S_PUT_B_LO = 3'd4,
    S_GET_Z_HI = 3'd5,
    S_GET_Z_LO = 3'd6,
    S_PUT_RES  = 3'd7
  } state_t;

endpackage

// File: rtl/fpu_hs_word.sv
// rtl/fpu_hs_word.sv - registered stb/ack word slot holding its data until accepted
module fpu_hs_word #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         stb
);

  // load has priority so the next word can replace the accepted one with no bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
      stb  <= 1'b0;
    end else if (load) begin
      data <= din;
      stb  <= 1'b1;
    end else if (stb && ack) begin
      stb <= 1'b0;
    end
  end

endmodule

// File: rtl/fpu_word_driver.sv
// rtl/fpu_word_driver.sv - host command to 16-bit word-serial FPU operand/result driver
module fpu_word_driver
  import fpu_word_driver_pkg::*;
#(
  parameter int LAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_stb,
  output logic              cmd_ack,
  output logic [DATA_W-1:0] res_z,
  output logic [LAT_W-1:0]  res_lat,
  output logic              res_stb,
  input  logic              res_ack,
  output logic [WORD_W-1:0] fpu_a,
  output logic              fpu_a_stb,
  input  logic              fpu_a_ack,
  output logic [WORD_W-1:0] fpu_b,
  output logic              fpu_b_stb,
  input  logic              fpu_b_ack,
  input  logic [WORD_W-1:0] fpu_z,
  input  logic              fpu_z_stb,
  output logic              fpu_z_ack,
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t              state;
  logic [WORD_W-1:0]   a_lo;
  logic [DATA_W-1:0]   b_hold;
  logic [WORD_W-1:0]   z_hi;
  logic [LAT_W-1:0]    cnt;
  logic [LAT_W-1:0]    cnt_next;
  logic                cmd_fire;
  logic                a_xfer;
  logic                b_xfer;
  logic                z_xfer;
  logic                a_load;
  logic                b_load;
  logic                r_load;
  logic [WORD_W-1:0]   a_din;
  logic [WORD_W-1:0]   b_din;
  logic [LAT_W+DATA_W-1:0] r_din;
  logic [LAT_W+DATA_W-1:0] r_word;

  assign cmd_fire = (state == S_IDLE) && cmd_stb && cmd_ack;
  assign a_xfer   = fpu_a_stb && fpu_a_ack;
  assign b_xfer   = fpu_b_stb && fpu_b_ack;
  assign z_xfer   = fpu_z_stb && fpu_z_ack;
  assign cnt_next = (cnt == LAT_MAX) ? cnt : cnt + LAT_ONE;
  assign busy     = (state != S_IDLE);
  assign res_z    = r_word[DATA_W-1:0];
  assign res_lat  = r_word[DATA_W +: LAT_W];

  // slot loads: each accepted word is replaced by the next one on the same edge
  always_comb begin
    a_load = 1'b0;
    b_load = 1'b0;
    r_load = 1'b0;
    a_din  = a_lo;
    b_din  = b_hold[WORD_W-1:0];
    r_din  = {cnt_next, z_hi, fpu_z};
    if (cmd_fire) begin
      a_load = 1'b1;
      a_din  = cmd_a[DATA_W-1:WORD_W];
    end
    if (state == S_PUT_A_HI && a_xfer) begin
      a_load = 1'b1;
    end
    if (state == S_PUT_A_LO && a_xfer) begin
      b_load = 1'b1;
      b_din  = b_hold[DATA_W-1:WORD_W];
    end
    if (state == S_PUT_B_HI && b_xfer) begin
      b_load = 1'b1;
    end
    if (state == S_GET_Z_LO && z_xfer) begin
      r_load = 1'b1;
    end
  end

  fpu_hs_word #(.W(WORD_W)) u_a_slot (
    .clk  (clk),
    .rst  (rst),
    .load (a_load),
    .din  (a_din),
    .ack  (fpu_a_ack),
    .data (fpu_a),
    .stb  (fpu_a_stb)
  );

  fpu_hs_word #(.W(WORD_W)) u_b_slot (
    .clk  (clk),
    .rst  (rst),
    .load (b_load),
    .din  (b_din),
    .ack  (fpu_b_ack),
    .data (fpu_b),
    .stb  (fpu_b_stb)
  );

  fpu_hs_word #(.W(LAT_W + DATA_W)) u_res_slot (
    .clk  (clk),
    .rst  (rst),
    .load (r_load),
    .din  (r_din),
    .ack  (res_ack),
    .data (r_word),
    .stb  (res_stb)
  );

  // sequencing FSM: operand words out in fixed order, result words in, latency counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cmd_ack   <= 1'b0;
      fpu_z_ack <= 1'b0;
      cnt       <= '0;
      a_lo      <= '0;
      b_hold    <= '0;
      z_hi      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            a_lo    <= cmd_a[WORD_W-1:0];
            b_hold  <= cmd_b;
            cmd_ack <= 1'b0;
            cnt     <= '0;
            state   <= S_PUT_A_HI;
          end else begin
            cmd_ack <= 1'b1;
          end
        end
        S_PUT_A_HI: begin
          cnt <= cnt_next;
          if (a_xfer) state <= S_PUT_A_LO;
        end
        S_PUT_A_LO: begin
          cnt <= cnt_next;
          if (a_xfer) state <= S_PUT_B_HI;
        end
        S_PUT_B_HI: begin
          cnt <= cnt_next;
          if (b_xfer) state <= S_PUT_B_LO;
        end
        S_PUT_B_LO: begin
          cnt <= cnt_next;
          if (b_xfer) begin
            fpu_z_ack <= 1'b1;
            state     <= S_GET_Z_HI;
          end
        end
        S_GET_Z_HI: begin
          cnt <= cnt_next;
          if (z_xfer) begin
            z_hi  <= fpu_z;
            state <= S_GET_Z_LO;
          end
        end
        S_GET_Z_LO: begin
          cnt <= cnt_next;
          if (z_xfer) begin
            fpu_z_ack <= 1'b0;
            state     <= S_PUT_RES;
          end
        end
        S_PUT_RES: begin
          if (res_stb && res_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
